// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - operation encodings (bit0 = unsigned, bit1 = div/sub, bit2 = accumulate)
//   - FSM state enum
//   - divide-by-zero result constant and iteration counter width helper
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MADDU = 3'b101,
    OP_MSUB  = 3'b110,
    OP_MSUBU = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_e;

  localparam int MdzResult = 0;

  // Iteration counter width for a given operand width.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Division is the only non-accumulating op with bit1 set.
  function automatic logic op_is_div(input logic [2:0] op);
    return !op[2] && op[1];
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return !op[0];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: combinational single-iteration datapath.
//   div_i   : 1 = restoring shift-subtract step, 0 = radix-2 shift-add step
//   work_i  : 2*WIDTH working register
//             MUL: {partial product high, remaining multiplier bits}
//             DIV: {partial remainder, dividend bits / quotient bits}
//   opnd_i  : multiplicand (MUL) or divisor (DIV), magnitude only
//   work_o  : working register after one iteration
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               div_i,
  input  logic [2*WIDTH-1:0] work_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] work_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           qbit;

  always_comb begin
    // Multiply: add the multiplicand when the current multiplier LSB is set,
    // then shift the whole register right, pulling the carry into the top.
    sum    = {1'b0, work_i[2*WIDTH-1:WIDTH]} + (work_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: shift left one, trial-subtract the divisor from the upper half.
    rem_sh = work_i[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opnd_i};
    qbit   = (rem_sh >= {1'b0, opnd_i});
    if (div_i) begin
      // The kept remainder is always below the divisor, so WIDTH bits suffice.
      work_o = {(qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), work_i[WIDTH-2:0], qbit};
    end else begin
      work_o = {sum, work_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide/accumulate unit for the EX stage.
//   clk, Rst_n   : clock, synchronous active-low reset
//   start_i      : request, held high until ready_o is seen
//   op_i         : mdu_pkg operation code
//   opdata1_i    : multiplicand / dividend
//   opdata2_i    : multiplier / divisor
//   acc_i        : {HI, LO} accumulator input for MADD/MSUB
//   annul_i      : flush, cancels any operation in flight
//   result_o     : {HI, LO} product/accumulation or {remainder, quotient}
//   ready_o      : result_o valid
//   busy_o       : iterating or applying the sign fix
//   div_zero_o   : last division had a zero divisor (valid with ready_o)
// Latency is WIDTH+2 edges from the start edge to ready_o; a zero divisor
// short-circuits to DONE and reports ready after one edge.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               Rst_n,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam int               RES_W    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [RES_W-1:0]   acc_q, acc_d;
  logic [RES_W-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               dz_q, dz_d;

  logic [RES_W-1:0]   step_out;
  logic [RES_W-1:0]   fix_res;
  logic [RES_W-1:0]   prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div_i  (op_is_div(op_q)),
    .work_i (work_q),
    .opnd_i (opnd_q),
    .work_o (step_out)
  );

  // Sign correction and accumulation applied to the unsigned magnitudes.
  always_comb begin
    prod_s = (neg_a_q ^ neg_b_q) ? -work_q : work_q;
    quo_s  = (neg_a_q ^ neg_b_q) ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    // Remainder follows the dividend's sign.
    rem_s  = neg_a_q ? -work_q[RES_W-1:WIDTH] : work_q[RES_W-1:WIDTH];
    if (op_q[2]) begin
      fix_res = op_q[1] ? (acc_q - prod_s) : (acc_q + prod_s);
    end else if (op_q[1]) begin
      fix_res = {rem_s, quo_s};
    end else begin
      fix_res = prod_s;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    result_d = result_q;
    dz_d     = dz_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          acc_d   = acc_i;
          neg_a_d = op_is_signed(op_i) && opdata1_i[WIDTH-1];
          neg_b_d = op_is_signed(op_i) && opdata2_i[WIDTH-1];
          // Operand A sits in the low half for both MUL (multiplier bits)
          // and DIV (dividend bits); operand B is the add/subtract operand.
          work_d  = {{WIDTH{1'b0}}, (neg_a_d ? -opdata1_i : opdata1_i)};
          opnd_d  = neg_b_d ? -opdata2_i : opdata2_i;
          cnt_d   = '0;
          if (op_is_div(op_i) && (opdata2_i == '0)) begin
            state_d  = DONE;
            result_d = RES_W'(MdzResult);
            dz_d     = 1'b1;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        work_d = step_out;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      FIX: begin
        result_d = fix_res;
        state_d  = DONE;
      end
      DONE: begin
        if (!start_i) begin
          state_d  = IDLE;
          result_d = '0;
          dz_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (annul_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = '0;
      dz_d     = 1'b0;
    end

    busy_d  = (state_d == CALC) || (state_d == FIX);
    // ready follows one edge after DONE is entered, and only while staying there.
    ready_d = (state_q == DONE) && (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      dz_q     <= dz_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q    <= op_d;
    acc_q   <= acc_d;
    work_q  <= work_d;
    opnd_q  <= opnd_d;
    neg_a_q <= neg_a_d;
    neg_b_q <= neg_b_d;
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign busy_o     = busy_q;
  assign div_zero_o = dz_q;

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide/accumulate unit serving the EX stage. It is the generalised successor of the fixed 32-bit divide path. It executes signed and unsigned MULT, DIV, MADD and MSUB over a configurable operand width in a fixed number of cycles. It uses the same start/ready handshake the EX stage already uses for stalling, and returns a {HI, LO} result for the HI/LO write port.

## Interface
- WIDTH, 32, operand width in bits; must be ≥ 4. Results are 2*WIDTH bits.
- clk  in  1  rising-edge clock
- Rst_n  in  1  reset, synchronous, active-low
- start_i  in  1  request; EX holds it high while stalled, drops it after ready_o
- op_i  in  3  operation code, from the mdu_pkg encoding
- opdata1_i  in  WIDTH  multiplicand or dividend
- opdata2_i  in  WIDTH  multiplier or divisor
- acc_i  in  2*WIDTH  forwarded {HI, LO} for MADD/MSUB; sampled with the operands
- annul_i  in  1  cancel the in-flight operation (flush)
- result_o  out  2*WIDTH  product/accumulation, or {remainder, quotient} for division
- ready_o  out  1  result_o valid
- busy_o  out  1  operation in progress
- div_zero_o  out  1  last division had divisor 0; valid with ready_o

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE:**
  - start_i=1 latches op_i, acc_i and the absolute values of both operands (absolute only for signed ops).
  - Records the result sign(s) and clears the counter.
  - Next state is CALC.
  - DIV/DIVU with opdata2_i=0 go directly to DONE with result_o=0 and div_zero_o=1.
- **CALC:**
  - Runs exactly WIDTH iterations, counter 0..WIDTH-1.
  - MUL: radix-2 shift-add into a 2*WIDTH accumulator.
  - DIV: restoring shift-subtract.
  - Leaves to FIX after the iteration with counter=WIDTH-1.
- **FIX:** applies sign correction and accumulation, then goes to DONE.
  - Signed product: negated if the operand signs differ.
  - Signed quotient: negated if the signs differ. Signed remainder: takes the sign of the dividend.
  - MADD/MADDU: result = acc + product. MSUB/MSUBU: result = acc − product. Both modulo 2^(2*WIDTH).
- **DONE:**
  - ready_o=1 and result_o holds while start_i=1.
  - start_i=0 returns to IDLE and clears result_o, ready_o and div_zero_o.
- **Overflow:** DIV of most-negative by −1 gives quotient = most-negative (wraps) and remainder = 0. No flag is raised.
- **Input changes:** start_i, op_i and operand changes while busy or in DONE are ignored.
- **Priority:** Rst_n low > annul_i > normal sequencing.
  - annul_i=1 in any state forces IDLE on the next edge, with all outputs cleared.
  - A start_i present in the same cycle as annul_i is not accepted.

## Timing
- **Reset values:** result_o=0, ready_o=0, busy_o=0, div_zero_o=0, state IDLE, counter 0.
- **Latency:** start sampled at edge 0 → ready_o=1 after edge WIDTH+2, for every op including MADD/MSUB. With WIDTH=32 that is 34 cycles.
- **Divide-by-zero:** ready_o=1 after edge 1.
- **busy_o:** 1 in CALC and FIX; 0 in IDLE and DONE.
- **Back-to-back:** after start_i drops, the unit spends one cycle in IDLE, so the minimum issue interval is WIDTH+4 cycles.
- **Outputs:** all registered; there is no combinational path from inputs to outputs.
- **Reset mid-operation:** a Rst_n low cycle behaves identically to annul_i.

## Structure
- **mdu_pkg** holds:
  - Op encodings: MULT=000, MULTU=001, DIV=010, DIVU=011, MADD=100, MADDU=101, MSUB=110, MSUBU=111. Bit0 = unsigned, bit1 = div/sub, bit2 = accumulate.
  - The state enum.
  - Helper constants MdzResult=0 and the counter width $clog2(WIDTH).
- **Sub-module mdu_step:** combinational one-iteration datapath (add-or-pass for MUL, trial-subtract for DIV), parametrised by WIDTH. The FSM, counter and sign fix stay in mdu_iter.

## Test plan
- MULT, WIDTH=32, 0xFFFFFFFE × 0x00000003 → result_o=0xFFFFFFFF_FFFFFFFA, ready_o rises exactly 34 cycles after start.
- DIV −7/2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD. DIVU 7/2 → HI=1, LO=3. DIV 0x80000000/0xFFFFFFFF → HI=0, LO=0x80000000.
- DIVU 5/0 → ready_o after 1 cycle, result_o=0, div_zero_o=1; start_i dropped → all outputs 0 next cycle.
- MSUB, acc_i=0x00000000_0000000A, 3×4 → 0xFFFFFFFF_FFFFFFFE. MADDU, acc_i=0xFFFFFFFF_FFFFFFFF, 1×1 → 0 (wrap).
- annul_i pulsed at cycle 10 of a DIV → busy_o=0 next cycle and ready_o never rises; a following MULTU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE_00000001.
- Rst_n low at cycle 20 of a MULT → all outputs 0 next edge; WIDTH=8 instance: MULT 0x80×0x80 → 0x4000 with ready_o after 10 cycles.
